// File: rtl/serial_subtractor_pkg.sv
// -----------------------------------------------------------------------------
// serial_sub_pkg
// Shared definitions for the bit-serial subtractor slice.
//   SUB_WIDTH_DEF : default operand/result width
//   sub_state_e   : controller states (IDLE, RUN, DONE)
// Optional feature macro used elsewhere in the slice: SERIAL_SUB_OVF_EN
// -----------------------------------------------------------------------------
package serial_sub_pkg;

  localparam int SUB_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// -----------------------------------------------------------------------------
// serial_subtractor_if
// Operand and result handshakes of the bit-serial subtractor.
//   start_valid / start_ready : operand pair a, b offered / accepted
//   diff_valid  / diff_ready  : result diff, borrow (and ovf) offered / taken
//   ovf                       : signed overflow, only when SERIAL_SUB_OVF_EN
// Modports:
//   master : producer/consumer side (drives operands, accepts results)
//   slave  : the subtractor itself
// -----------------------------------------------------------------------------
interface serial_subtractor_if
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEF
) ();

  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             diff_valid;
  logic             diff_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

`ifdef SERIAL_SUB_OVF_EN
  modport master (
    output start_valid, a, b, diff_ready,
    input  start_ready, diff_valid, diff, borrow, ovf
  );

  modport slave (
    input  start_valid, a, b, diff_ready,
    output start_ready, diff_valid, diff, borrow, ovf
  );
`else
  modport master (
    output start_valid, a, b, diff_ready,
    input  start_ready, diff_valid, diff, borrow
  );

  modport slave (
    input  start_valid, a, b, diff_ready,
    output start_ready, diff_valid, diff, borrow
  );
`endif

endinterface

// File: rtl/serial_subtractor_fs.sv
// -----------------------------------------------------------------------------
// FS
// Combinational one-bit full subtractor: D = A - B - Bin, Bout = borrow out.
// Ports:
//   A, B, Bin : minuend bit, subtrahend bit, borrow in
//   D, Bout   : difference bit, borrow out
// -----------------------------------------------------------------------------
module FS (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic D,
  output logic Bout
);

  logic w_axb;

  assign w_axb = A ^ B;
  assign D     = w_axb ^ Bin;
  // Borrow when B exceeds A outright, or when they tie and a borrow comes in.
  assign Bout  = (~A & B) | (~w_axb & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial, LSB-first two's-complement subtractor computing a - b over WIDTH
// clock cycles with one FS cell and a rippled borrow register.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : serial_subtractor_if.slave (operand and result handshakes)
// Parameter:
//   WIDTH : operand/result width, 2..32
// Optional feature: SERIAL_SUB_OVF_EN adds the ovf output and the captured
// operand sign pair used to compute it.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | start_ready high, waiting for an operand pair
// RUN   | one bit per cycle through the FS cell, LSB first
// DONE  | diff_valid high, result held until the consumer takes it
// -----------------------------------------------------------------------------
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  sub_state_e       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_diff;
  logic [CNT_W-1:0] r_cnt;
  logic             r_borrow;

  logic w_d;
  logic w_bout;
  logic w_accept;
  logic w_last;

`ifdef SERIAL_SUB_OVF_EN
  logic r_a_sign;
  logic r_b_sign;
  logic r_ovf;
`endif

  FS u_fs (
    .A    (r_a[0]),
    .B    (r_b[0]),
    .Bin  (r_borrow),
    .D    (w_d),
    .Bout (w_bout)
  );

  assign w_accept = (r_state == IDLE) & bus.start_valid;
  assign w_last   = (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE:    if (bus.start_valid) r_state <= RUN;
        RUN:     if (w_last)          r_state <= DONE;
        DONE:    if (bus.diff_ready)  r_state <= IDLE;
        default:                      r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_cnt    <= '0;
      r_borrow <= 1'b0;
    end else if (w_accept) begin
      r_a      <= bus.a;
      r_b      <= bus.b;
      r_cnt    <= '0;
      r_borrow <= 1'b0;
    end else if (r_state == RUN) begin
      r_a      <= r_a >> 1;
      r_b      <= r_b >> 1;
      r_diff   <= {w_d, r_diff[WIDTH-1:1]};
      r_borrow <= w_bout;
      // Hold on the last bit so the counter never wraps.
      if (!w_last) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sign <= 1'b0;
      r_b_sign <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_a_sign <= bus.a[WIDTH-1];
      r_b_sign <= bus.b[WIDTH-1];
      r_ovf    <= 1'b0;
    end else if ((r_state == RUN) && w_last) begin
      // w_d is the result MSB being shifted in on this edge.
      r_ovf <= (r_a_sign != r_b_sign) & (w_d != r_a_sign);
    end
  end

  assign bus.ovf = r_ovf;
`endif

  // Outputs come straight from flops or decode of the state flop only.
  assign bus.start_ready = (r_state == IDLE);
  assign bus.diff_valid  = (r_state == DONE);
  assign bus.diff        = r_diff;
  assign bus.borrow      = r_borrow;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;
  import serial_sub_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic int ref_diff(input int a, input int b);
    return (a - b + (1 << W)) % (1 << W);
  endfunction

  function automatic int ref_borrow(input int a, input int b);
    return (a < b) ? 1 : 0;
  endfunction

  function automatic int ref_ovf(input int a, input int b);
    int sa, sb, s;
    sa = (a >= (1 << (W-1))) ? a - (1 << W) : a;
    sb = (b >= (1 << (W-1))) ? b - (1 << W) : b;
    s  = sa - sb;
    return ((s > (1 << (W-1)) - 1) || (s < -(1 << (W-1)))) ? 1 : 0;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, " start_ready"}, 32'(bus.start_ready), 32'd1);
    check({tag, " diff_valid"},  32'(bus.diff_valid),  32'd0);
    check({tag, " diff"},        32'(bus.diff),        32'd0);
    check({tag, " borrow"},      32'(bus.borrow),      32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check({tag, " ovf"},         32'(bus.ovf),         32'd0);
`endif
  endtask

  // Wait for start_ready, accept one pair on the next edge (T0).
  task automatic accept_op(input int a, input int b, input bit rdy, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 50; i++) begin
      if (bus.start_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      check("start_ready timeout", 32'd0, 32'd1);
      return;
    end
    bus.a           = W'(a);
    bus.b           = W'(b);
    bus.start_valid = 1'b1;
    bus.diff_ready  = rdy;
    @(posedge clk);
    #1;
    bus.start_valid = 1'b0;
  endtask

  task automatic run_op(input int a, input int b, input int hold, input bit inject, input string tag);
    int  lat;
    int  ed, eb;
    bit  ok;
    bit  stable;
    ed = ref_diff(a, b);
    eb = ref_borrow(a, b);
    accept_op(a, b, (hold == 0), ok);
    if (!ok) return;
    check({tag, " busy after accept"}, 32'(bus.start_ready), 32'd0);
    lat = 0;
    while (!bus.diff_valid && lat < 40) begin
      if (inject) begin
        bus.start_valid = (lat == 2);
        bus.a           = 8'h11;
        bus.b           = 8'h01;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    bus.start_valid = 1'b0;
    check({tag, " latency"}, 32'(lat), 32'(W));
    check({tag, " diff"},    32'(bus.diff),   32'(ed));
    check({tag, " borrow"},  32'(bus.borrow), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
    check({tag, " ovf"},     32'(bus.ovf),    32'(ref_ovf(a, b)));
`endif
    check({tag, " ready low in DONE"}, 32'(bus.start_ready), 32'd0);
    stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      if (!bus.diff_valid || bus.diff !== W'(ed) || bus.borrow !== eb[0] || bus.start_ready)
        stable = 1'b0;
    end
    if (hold > 0) check({tag, " held stable"}, 32'(stable), 32'd1);
    bus.diff_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, " valid drop"}, 32'(bus.diff_valid),  32'd0);
    check({tag, " ready back"}, 32'(bus.start_ready), 32'd1);
    bus.diff_ready = 1'b0;
  endtask

  task automatic reset_mid_run();
    bit ok;
    accept_op(8'h55, 8'h2A, 1'b1, ok);
    if (!ok) return;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid-run reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready after release", 32'(bus.start_ready), 32'd1);
    check("no valid after release", 32'(bus.diff_valid), 32'd0);
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.start_valid = 1'b0;
    bus.a           = '0;
    bus.b           = '0;
    bus.diff_ready  = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle after reset", 32'(bus.start_ready), 32'd1);

    run_op(8'h05, 8'h03, 0, 1'b0, "5-3");
    run_op(8'h03, 8'h05, 0, 1'b0, "3-5");
    run_op(8'h80, 8'h01, 0, 1'b0, "80-1");
    run_op(8'h00, 8'h00, 5, 1'b0, "0-0 hold");
    run_op(8'h40, 8'h10, 0, 1'b1, "40-10 inject");
    reset_mid_run();
    run_op(8'h0A, 8'h0A, 0, 1'b0, "A-A after reset");
    run_op(8'hFF, 8'h00, 0, 1'b0, "FF-0");
    run_op(8'h00, 8'hFF, 1, 1'b0, "0-FF");
    run_op(8'h7F, 8'h80, 0, 1'b0, "7F-80");
    run_op(8'h80, 8'h7F, 2, 1'b0, "80-7F");

    for (int i = 0; i < 30; i++) begin
      run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 3)), 1'b0, "random");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    n_bad++;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial, LSB-first two's-complement subtractor. It computes `a - b` over `WIDTH` clock cycles using one full-subtractor cell and a rippled borrow register. It is the subtract-direction counterpart to the ripple adder cells in the arithmetic library, and is intended for area-constrained accumulate/correct paths in the matrix-multiplier datapath. Operands enter and results leave through valid/ready handshakes.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width in bits; legal range 2..32.

Ports:
- `clk`  in  1  single clock; all logic is clocked on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset. Assertion is asynchronous; deassertion is synchronised externally.
- `start_valid`  in  1  operands `a` and `b` are valid.
- `start_ready`  out  1  block can accept operands; high only in IDLE.
- `a`  in  WIDTH  minuend; sampled on the accept edge.
- `b`  in  WIDTH  subtrahend; sampled on the accept edge.
- `diff_valid`  out  1  result is valid; high only in DONE.
- `diff_ready`  in  1  consumer accepts the result.
- `diff`  out  WIDTH  `a - b` modulo 2^WIDTH.
- `borrow`  out  1  final borrow-out; 1 when unsigned `a < b`.
- `ovf`  out  1  signed overflow; present only with `SERIAL_SUB_OVF_EN`.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - `start_ready` = 1.
  - On `start_valid & start_ready`: load `a` and `b` into right-shift registers, clear the borrow register, clear the bit counter, go to RUN.
- **RUN**, once per cycle:
  - Full-subtractor cell: d = a0 ^ b0 ^ bin; bout = (~a0 & b0) | (~(a0 ^ b0) & bin).
  - Shift d into the MSB of the diff shift register.
  - Shift the a and b registers right by one.
  - borrow register <= bout; counter increments.
  - When the counter reaches WIDTH-1, this bit is the last one; go to DONE.
- **DONE**
  - `diff_valid` = 1.
  - `diff`, `borrow` and `ovf` are held stable until `diff_valid & diff_ready`.
  - On that handshake, go to IDLE.
- `start_valid` is ignored in RUN and DONE. No error is raised and no operand is captured.
- No back-to-back overlap: a new operand pair is accepted no earlier than the cycle after the result handshake.
- Counter width is $clog2(WIDTH). Counting is exact, so wrap-around never occurs.

## Timing
- Reset values: `start_ready`=1 (IDLE), `diff_valid`=0, `diff`=0, `borrow`=0, `ovf`=0. All internal registers are 0.
- Accept edge is T0. Bits are processed on edges T1..TWIDTH. `diff_valid` rises after edge TWIDTH.
  - Latency is WIDTH cycles from accept to valid result.
  - Throughput is one result per WIDTH+2 cycles when the consumer is always ready.
- `start_ready` drops on the edge after accept and returns on the edge after the result handshake.
- Reset asserted mid-RUN or in DONE:
  - Returns immediately (asynchronously) to IDLE with reset values.
  - The partial result is discarded.
  - `start_ready`=1 on the first cycle after deassertion.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- `SERIAL_SUB_OVF_EN` defined:
  - The `ovf` port and a 1-bit captured `a[WIDTH-1]`/`b[WIDTH-1]` sign pair exist.
  - At the transition to DONE, `ovf` = (a_sign != b_sign) & (diff[WIDTH-1] != a_sign).
  - `ovf` holds with `diff` and resets to 0.
- Not defined: the `ovf` port and the sign capture registers are absent. All other behaviour is identical.

## Structure
- Package `serial_sub_pkg` holds:
  - the FSM enum typedef `sub_state_e` (IDLE, RUN, DONE);
  - the default width constant `SUB_WIDTH_DEF = 8`.
- One sub-module: `FS`, a combinational full-subtractor cell (A, B, Bin -> D, Bout), instantiated once in the top.
- Top: `serial_subtractor`, containing the FSM, shift registers, counter and borrow register.

## Test plan
All scenarios use WIDTH=8.
- a=0x05, b=0x03, `diff_ready`=1 -> `diff`=0x02, `borrow`=0, `diff_valid` high 8 cycles after accept.
- a=0x03, b=0x05 -> `diff`=0xFE, `borrow`=1; with OVF_EN, `ovf`=0.
- a=0x80, b=0x01 -> `diff`=0x7F, `borrow`=0; with OVF_EN, `ovf`=1.
- a=0x00, b=0x00 -> `diff`=0x00, `borrow`=0. Then hold `diff_ready`=0 for 5 cycles -> `diff_valid`/`diff` stay stable, and `start_ready` stays 0 throughout.
- Pulse `start_valid` with a=0x11 during RUN of a=0x40, b=0x10 -> ignored; result is 0x30, `borrow`=0.
- Assert `rst_n`=0 after bit 3 of a run -> all outputs go to reset values; `start_ready`=1 the cycle after release; the next operation (0x0A-0x0A) yields 0x00.
